// File: rtl/pc_conf_decoder_pkg.sv
// Shared address layout for the PC configuration word stream. The decoder RTL and
// the host driver generator both read these constants so that they cannot drift apart.
package pc_conf_pkg;

    localparam int unsigned NADDR_DEF = 8;
    localparam int unsigned NCONF_DEF = 16;
    localparam int unsigned Nin       = NADDR_DEF + NCONF_DEF;

    // The all-ones address is reserved as a NOP so the host can pad its stream
    function automatic logic [31:0] nop_addr(input int unsigned naddr);
        return (32'd1 << naddr) - 32'd1;
    endfunction

    localparam logic [31:0] NOP_ADDR = nop_addr(NADDR_DEF);

    function automatic logic addr_is_reg(input logic [31:0] addr, input int unsigned nreg);
        return addr < nreg;
    endfunction

    function automatic logic addr_is_chan(input logic [31:0] addr, input int unsigned nreg,
                                          input int unsigned nchan);
        return (addr >= nreg) && (addr < nreg + nchan);
    endfunction

    function automatic logic addr_is_nop(input logic [31:0] addr, input int unsigned naddr);
        return addr == nop_addr(naddr);
    endfunction

endpackage

// File: rtl/pc_conf_decoder_if.sv
// Word-stream input and configuration-channel output handshakes of the decoder.
interface pc_conf_decoder_if
    import pc_conf_pkg::*;
#(
    parameter int unsigned Naddr = NADDR_DEF,
    parameter int unsigned Nconf = NCONF_DEF,
    parameter int unsigned Nchan = 1
);
    logic [Naddr+Nconf-1:0] in_d;
    logic                   in_v;
    logic                   in_a;
    logic [Nchan*Nconf-1:0] conf_chan_d;
    logic [Nchan-1:0]       conf_chan_v;
    logic [Nchan-1:0]       conf_chan_a;

    modport master (
        output in_d, in_v, conf_chan_a,
        input  in_a, conf_chan_d, conf_chan_v
    );

    modport slave (
        input  in_d, in_v, conf_chan_a,
        output in_a, conf_chan_d, conf_chan_v
    );
endinterface

// File: rtl/pc_conf_reg_bank.sv
// Configuration register array; unwritten registers read through to the mapper's
// reset values so outputs are correct immediately after reset without a load cycle.
module pc_conf_reg_bank #(
    parameter int unsigned Nconf = 16,
    parameter int unsigned Nreg  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [Nreg-1:0]        wr_sel,
    input  logic [Nconf-1:0]       wr_data,
    input  logic [Nreg*Nconf-1:0]  reset_vals,
    output logic [Nreg*Nconf-1:0]  reg_out
);
    logic [Nreg*Nconf-1:0] data;
    logic [Nreg-1:0]       written;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data    <= '0;
            written <= '0;
        end else begin
            for (int r = 0; r < Nreg; r++) begin
                if (wr_sel[r]) begin
                    data[r*Nconf +: Nconf] <= wr_data;
                    written[r]             <= 1'b1;
                end
            end
        end
    end

    for (genvar r = 0; r < Nreg; r++) begin : g_mux
        assign reg_out[r*Nconf +: Nconf] = written[r] ? data[r*Nconf +: Nconf]
                                                      : reset_vals[r*Nconf +: Nconf];
    end
endmodule

// File: rtl/pc_conf_decoder.sv
// Decodes {address, payload} words into register writes or channel forwards for the
// PC configuration mapper, counting words that hit unmapped addresses.
module pc_conf_decoder
    import pc_conf_pkg::*;
#(
    parameter int unsigned Nconf = 16,
    parameter int unsigned Nreg  = 64,
    parameter int unsigned Nchan = 1,
    parameter int unsigned Naddr = 8,
    parameter int unsigned Nbad  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    pc_conf_decoder_if.slave       bus,
    input  logic [Nreg*Nconf-1:0]  conf_reg_reset_vals,
    output logic [Nreg*Nconf-1:0]  conf_reg_out,
    output logic [Nbad-1:0]        bad_addr_count
);
    localparam int unsigned Nw = Naddr + Nconf;

    if (Nreg + Nchan > (2**Naddr) - 1) begin : g_bad_params
        $error("pc_conf_decoder: Nreg+Nchan does not fit below the NOP address");
    end

    function automatic logic [Nbad-1:0] sat_inc(input logic [Nbad-1:0] v);
        return (&v) ? v : v + Nbad'(1);
    endfunction

    logic [31:0]       addr_w;
    logic [Nconf-1:0]  pay;
    logic              is_reg, is_chan, is_nop, is_bad;
    logic              acc, drain;
    logic [Nchan-1:0]  chan_sel;
    logic [Nreg-1:0]   wr_sel;
    logic [Nchan-1:0]  chan_vld_p1;
    logic [Nconf-1:0]  chan_pay_p1;
    logic [Nbad-1:0]   bad_cnt;

    assign addr_w  = 32'(bus.in_d[Nw-1:Nconf]);
    assign pay     = bus.in_d[Nconf-1:0];
    assign is_reg  = addr_is_reg(addr_w, Nreg);
    assign is_chan = addr_is_chan(addr_w, Nreg, Nchan);
    assign is_nop  = addr_is_nop(addr_w, Naddr);
    assign is_bad  = !(is_reg || is_chan || is_nop);

    // Every word class waits behind a pending channel word to keep strict ordering
    assign drain  = |(chan_vld_p1 & bus.conf_chan_a);
    assign bus.in_a = !reset && (!(|chan_vld_p1) || drain);
    assign acc    = bus.in_v && bus.in_a;

    always_comb begin
        chan_sel = '0;
        for (int unsigned i = 0; i < Nchan; i++) chan_sel[i] = (addr_w == Nreg + i);
    end

    always_comb begin
        wr_sel = '0;
        for (int unsigned r = 0; r < Nreg; r++) wr_sel[r] = acc && is_reg && (addr_w == r);
    end

    pc_conf_reg_bank #(.Nconf(Nconf), .Nreg(Nreg)) u_reg_bank (
        .clk        (clk),
        .reset      (reset),
        .wr_sel     (wr_sel),
        .wr_data    (pay),
        .reset_vals (conf_reg_reset_vals),
        .reg_out    (conf_reg_out)
    );

    // Stage p1: single-entry channel output register, one-hot valid held directly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_vld_p1 <= '0;
            bad_cnt     <= '0;
        end else begin
            if (acc && is_chan) chan_vld_p1 <= chan_sel;
            else if (drain)     chan_vld_p1 <= '0;
            if (acc && is_bad)  bad_cnt     <= sat_inc(bad_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (acc && is_chan) chan_pay_p1 <= pay;
    end

    assign bus.conf_chan_v = chan_vld_p1;
    assign bus.conf_chan_d = {Nchan{chan_pay_p1}};
    assign bad_addr_count  = bad_cnt;
endmodule

// File: doc/pc_conf_decoder.md
Name: pc_conf_decoder

Overview:
- Upstream neighbour of the PC configuration mapper; sits between the PC downstream word stream and the mapper.
- Decodes each incoming {address, payload} word into one of two actions:
  - a write to one of Nreg configuration registers, or
  - a payload forwarded on one of Nchan configuration channels (e.g. the spike-generator program-memory deserializer).
- Supplies the mapper's register array and channel array, and takes register reset values from the mapper.

Parameters:
- Nconf, 16: payload width; width of each register and each channel word.
- Nreg, 64: number of configuration registers.
- Nchan, 1: number of configuration channels.
- Naddr, 8: address field width. Legal only if Nreg+Nchan <= 2**Naddr-1.
- Nbad, 8: width of the bad-address counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_d  in  Naddr+Nconf  input word: address in [Naddr+Nconf-1:Nconf], payload in [Nconf-1:0].
- in_v  in  1  input valid.
- in_a  out  1  input accept; transfer occurs on the edge where in_v&&in_a.
- conf_reg_reset_vals  in  Nreg*Nconf  per-register reset value (register r at [r*Nconf+:Nconf]).
- conf_reg_out  out  Nreg*Nconf  current register values.
- conf_chan_d  out  Nchan*Nconf  channel payloads.
- conf_chan_v  out  Nchan  channel valid.
- conf_chan_a  in  Nchan  channel accept.
- bad_addr_count  out  Nbad  saturating count of words with unmapped addresses.

Behaviour:
- Address decode:
  - A < Nreg: register write.
  - Nreg <= A < Nreg+Nchan: channel A-Nreg.
  - A == 2**Naddr-1: NOP; consumed, no effect, not counted.
  - Any other address: bad; consumed, and bad_addr_count increments.
- Register bank:
  - Each register holds data[r] plus a written[r] bit.
  - conf_reg_out[r] = written[r] ? data[r] : conf_reg_reset_vals[r], combinationally.
  - Reset clears written[] asynchronously, so outputs follow the reset values during and after reset without a load cycle.
- Register write:
  - On the accepting edge, data[r] <= payload and written[r] <= 1.
  - New value visible on conf_reg_out 1 cycle after acceptance.
  - Back-to-back writes to the same register: last one wins.
- Channel path (single-entry output stage):
  - Accepted channel word is loaded into stage {full, idx, payload} on the accepting edge.
  - conf_chan_v[idx] = full; all other conf_chan_v bits are 0.
  - conf_chan_d carries the stage payload in slot idx; other slots hold the stage payload too (don't-care).
  - Stage drains on the edge where conf_chan_v[idx]&&conf_chan_a[idx].
  - Latency: channel word valid 1 cycle after acceptance.
- Ordering is strict. in_a = !reset && (!full || conf_chan_a[idx]).
  - Register writes, NOPs and bad words are stalled behind a pending channel word.
  - Drain and new acceptance on the same edge is allowed: stage reloads (if channel word) or empties (otherwise). Throughput is 1 word/cycle when the channel consumer always accepts.
- bad_addr_count:
  - Increments on each bad-address acceptance.
  - Saturates at 2**Nbad-1.
  - Cleared only by reset.
- Reset values / mid-operation reset:
  - Asynchronously clears full, written[], data[] and bad_addr_count.
  - in_a=0 and conf_chan_v=0 while reset is high.
  - A pending channel word is discarded.
  - conf_reg_out reverts to reset values immediately.
- Outputs are glitch-free, registered or reset-value mux only; no combinational path from in_v to any output except in_a (in_a has no in_v dependence).

Decomposition:
- Package pc_conf_pkg holds:
  - the NOP address constant;
  - functions addr_is_reg, addr_is_chan, addr_is_nop;
  - the derived localparam Nin = Naddr+Nconf;
  - the shared address layout, so the host driver generator reads the same constants.
- One sub-module: pc_conf_reg_bank (data/written arrays, write port, reset-value mux). Decode, output stage and counter stay in the top.

Test Plan:
- Register write after reset: with reset_vals[5]=10000, check conf_reg_out[5]=10000. Then send {5,0x1234}; conf_reg_out[5]=0x1234 one cycle later, all other registers unchanged.
- Channel forwarding: Nchan=2. Send {65,0xBEEF} with conf_chan_a[1] held 0 for 3 cycles.
  - conf_chan_v=2'b10 and d=0xBEEF from cycle+1.
  - in_a=0 until conf_chan_a[1]=1; drains on that edge.
- Ordering: send {64,0x1111} (chan_a low) then {3,0x0007}. Register 3 must not change until the channel word is accepted; then it updates on the following edge.
- Bad/NOP/saturation (Nbad=2):
  - Send addr 0xFF ×2: count stays 0.
  - Send addr 100 ×5: count=3 (saturated); no register or channel activity.
- Streaming: 8 channel words back-to-back with chan_a=1. in_a stays 1 throughout; 8 outputs delivered in order on consecutive cycles.
- Mid-operation reset: assert reset while a channel word is pending and register 0 has been written.
  - conf_chan_v=0 and conf_reg_out[0]=reset_vals[0] in the same cycle.
  - After deassert, in_a=1 and count=0.
